// File: rtl/ucie_sb_tx_arbiter.sv
// ucie_sb_tx_arbiter: round-robin UCIe sideband TX arbiter/serializer with minimum inter-packet gap.
// Define UCIE_SB_TX_ARB_STATS_EN to add per-requester saturating grant counters (grant_cnt).
module ucie_sb_tx_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int PKT_BITS = 64,
    parameter int GAP_UI   = 32
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        sb_reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*PKT_BITS-1:0] req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        sbtx_data,
    output logic                        sbtx_clk_en,
    output logic                        busy,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id
`ifdef UCIE_SB_TX_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]       grant_cnt
`endif
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int BW = $clog2(PKT_BITS);
    localparam int GW = $clog2(GAP_UI + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t              state_q;
    logic [PKT_BITS-1:0] shreg_q;
    logic [PKT_BITS-1:0] win_data;
    logic [BW-1:0]       bit_cnt_q;
    logic [GW-1:0]       gap_cnt_q;
    logic [IW-1:0]       ptr_q;
    logic [IW-1:0]       ptr_d;
    logic [IW-1:0]       grant_q;
    logic [IW-1:0]       win;
    logic                data_q;
    logic                clk_en_q;
    logic                found;
    logic                bit_last;
    logic                gap_last;
    logic                hs;

    assign bit_last    = bit_cnt_q == BW'(PKT_BITS - 1);
    assign gap_last    = gap_cnt_q == GW'(GAP_UI - 1);
    assign hs          = (state_q == IDLE || (state_q == GAP && gap_last)) && found && reset_n && !sb_reset;
    assign ptr_d       = win == IW'(NUM_REQ - 1) ? '0 : win + 1'b1;
    assign win_data    = req_data[win*PKT_BITS +: PKT_BITS];
    assign req_ready   = hs ? NUM_REQ'(1) << win : '0;
    assign sbtx_data   = data_q;
    assign sbtx_clk_en = clk_en_q;
    assign busy        = state_q != IDLE;
    assign grant_id    = grant_q;

    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req_valid[(int'(ptr_q) + k) % NUM_REQ]) begin
                found = 1'b1;
                win   = IW'((int'(ptr_q) + k) % NUM_REQ);
            end
        end
    end

    // bit 0 goes straight to the output register, so the shifter holds the remaining bits
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            ptr_q     <= '0;
            grant_q   <= '0;
            data_q    <= 1'b0;
            clk_en_q  <= 1'b0;
        end else if (sb_reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            data_q    <= 1'b0;
            clk_en_q  <= 1'b0;
        end else if (hs) begin
            state_q   <= SHIFT;
            shreg_q   <= win_data >> 1;
            data_q    <= win_data[0];
            clk_en_q  <= 1'b1;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            grant_q   <= win;
            ptr_q     <= ptr_d;
        end else if (state_q == SHIFT) begin
            if (bit_last) begin
                state_q   <= GAP;
                data_q    <= 1'b0;
                clk_en_q  <= 1'b0;
                gap_cnt_q <= '0;
            end else begin
                shreg_q   <= shreg_q >> 1;
                data_q    <= shreg_q[0];
                bit_cnt_q <= bit_cnt_q + 1'b1;
            end
        end else if (state_q == GAP) begin
            if (gap_last) state_q <= IDLE;
            else gap_cnt_q <= gap_cnt_q + 1'b1;
        end
    end

`ifdef UCIE_SB_TX_ARB_STATS_EN
    logic [15:0] cnt_q [NUM_REQ];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < NUM_REQ; k++) cnt_q[k] <= '0;
        end else if (hs && cnt_q[win] != 16'hFFFF) begin
            cnt_q[win] <= cnt_q[win] + 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_cnt
        assign grant_cnt[i*16 +: 16] = cnt_q[i];
    end
`endif
endmodule

// File: tb/tb_ucie_sb_tx_arbiter.sv
// tb_ucie_sb_tx_arbiter: randomized scoreboard bench; a timeline model predicts handshakes,
// serialized packets and busy, and a negedge monitor compares what the DUT presents.
module tb_ucie_sb_tx_arbiter;
    localparam int N   = 4;
    localparam int PB  = 64;
    localparam int GAP = 32;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            sb_reset = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*PB-1:0] req_data = '0;
    logic [N-1:0]    req_ready;
    logic            sbtx_data;
    logic            sbtx_clk_en;
    logic            busy;
    logic [1:0]      grant_id;
`ifdef UCIE_SB_TX_ARB_STATS_EN
    logic [N*16-1:0] grant_cnt;
`endif

    ucie_sb_tx_arbiter #(.NUM_REQ(N), .PKT_BITS(PB), .GAP_UI(GAP)) dut (
        .clk(clk), .reset_n(reset_n), .sb_reset(sb_reset), .req_valid(req_valid),
        .req_data(req_data), .req_ready(req_ready), .sbtx_data(sbtx_data),
        .sbtx_clk_en(sbtx_clk_en), .busy(busy), .grant_id(grant_id)
`ifdef UCIE_SB_TX_ARB_STATS_EN
        , .grant_cnt(grant_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {int id; logic [63:0] data; int start;} pkt_t;
    typedef struct {logic [N-1:0] ready; logic busy;} cyc_t;

    pkt_t        pkt_q[$];
    cyc_t        cyc_q[$];
    int          vectors = 0, errors = 0, cyc = 0;
    bit          pend[N];
    logic [63:0] pdata[N];
    int          ptr = 0, free_at = 0, bfrom = 1, buntil = 0, last_hs = -1000;
    bit          inflight = 0;
    int          exp_aborts = 0, seen_aborts = 0;
    int          gcnt[N];

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i] = pend[i];
            req_data[i*PB +: PB] = pdata[i];
        end
    endtask

    // One UI: apply inputs, then predict this cycle's handshake and busy from the packet timeline
    task automatic step(input bit sbr, input bit refill);
        cyc_t e;
        int   g;
        @(posedge clk);
        #1;
        cyc++;
        reset_n  = 1'b1;
        sb_reset = sbr;
        if (refill)
            for (int i = 0; i < N; i++)
                if (!pend[i]) begin pend[i] = 1'b1; pdata[i] = {$urandom, $urandom}; end
        drive();
        e.ready = '0;
        e.busy  = cyc >= bfrom && cyc <= buntil;
        g = -1;
        for (int k = 0; k < N; k++)
            if (g < 0 && pend[(ptr + k) % N]) g = (ptr + k) % N;
        if (sbr) begin
            if (inflight && cyc <= last_hs + PB - 1) begin
                void'(pkt_q.pop_back());
                exp_aborts++;
            end
            inflight = 0;
            if (buntil > cyc) buntil = cyc;
            free_at = cyc + 1;
        end else if (cyc >= free_at && g >= 0) begin
            e.ready[g] = 1'b1;
            pkt_q.push_back('{g, pdata[g], cyc + 1});
            ptr      = (g + 1) % N;
            free_at  = cyc + PB + GAP;
            bfrom    = cyc + 1;
            buntil   = cyc + PB + GAP;
            last_hs  = cyc;
            inflight = 1;
            pend[g]  = 1'b0;
            gcnt[g]++;
        end
        cyc_q.push_back(e);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        cyc++;
        reset_n  = 1'b0;
        sb_reset = 1'b0;
        drive();
        #1;
        chk("reset sbtx_data", sbtx_data, 0);
        chk("reset clk_en", sbtx_clk_en, 0);
        chk("reset busy", busy, 0);
        chk("reset grant_id", grant_id, 0);
        cyc_q.push_back('{'0, 1'b0});
        ptr = 0; free_at = cyc + 1; buntil = -1; inflight = 0;
        for (int i = 0; i < N; i++) gcnt[i] = 0;
    endtask

    // Monitor: compares handshake/busy every cycle and reassembles serialized packets
    initial begin
        cyc_t        e;
        pkt_t        p;
        logic [63:0] sh = '0;
        int          nb = 0, st = 0;
        forever begin
            @(negedge clk);
            if (cyc_q.size() > 0) begin
                e = cyc_q.pop_front();
                chk("req_ready", req_ready, e.ready);
                chk("busy", busy, e.busy);
            end
            if (sbtx_clk_en === 1'b1) begin
                if (nb == 0) st = cyc;
                sh[nb] = sbtx_data;
                nb++;
                if (nb == PB) begin
                    nb = 0;
                    if (pkt_q.size() == 0) begin
                        vectors++; errors++;
                        $display("FAIL unexpected packet at cycle %0d: got %h expected none", cyc, sh);
                    end else begin
                        p = pkt_q.pop_front();
                        chk("packet data", sh, p.data);
                        chk("grant_id", grant_id, 64'(p.id));
                        chk("packet start cycle", 64'(st), 64'(p.start));
                    end
                end
            end else begin
                chk("idle sbtx_data", sbtx_data, 0);
                if (nb > 0) begin seen_aborts++; nb = 0; end
            end
        end
    end

    initial begin
        for (int i = 0; i < N; i++) begin pend[i] = 0; pdata[i] = '0; gcnt[i] = 0; end
        repeat (3) pulse_reset();
        // single packet
        pend[0] = 1; pdata[0] = 64'hA5A5_0000_FFFF_1234;
        repeat (110) step(0, 0);
        // sparse: req 2, then req 1 arriving mid-shift
        pend[2] = 1; pdata[2] = {$urandom, $urandom};
        repeat (10) step(0, 0);
        pend[1] = 1; pdata[1] = {$urandom, $urandom};
        repeat (200) step(0, 0);
        // sb_reset in the middle of a packet with another request pending
        pend[0] = 1; pdata[0] = {$urandom, $urandom};
        step(0, 0);
        while (cyc < last_hs + 21) step(0, 0);
        pend[3] = 1; pdata[3] = {$urandom, $urandom};
        step(1, 0);
        repeat (200) step(0, 0);
        // continuous load from every requester, then reset in a gap
        repeat (5 * (PB + GAP) + 10) step(0, 1);
        for (int i = 0; i < N; i++) pend[i] = 0;
        while (cyc < last_hs + PB + 16) step(0, 0);
        pulse_reset();
        pend[0] = 1; pdata[0] = {$urandom, $urandom};
        pend[3] = 1; pdata[3] = {$urandom, $urandom};
        repeat (300) step(0, 0);
        // random traffic with withdrawals and occasional flushes
        repeat (4000) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(39) == 0) begin
                    pend[i] = 1; pdata[i] = {$urandom, $urandom};
                end else if (pend[i] && $urandom_range(299) == 0) begin
                    pend[i] = 0;
                end
            end
            step($urandom_range(599) == 0, 0);
        end
        for (int i = 0; i < N; i++) pend[i] = 0;
        repeat (PB + GAP + 10) step(0, 0);
        @(negedge clk);
        #1;
        chk("undelivered packets", 64'(pkt_q.size()), 0);
        chk("aborted packets", 64'(seen_aborts), 64'(exp_aborts));
`ifdef UCIE_SB_TX_ARB_STATS_EN
        for (int i = 0; i < N; i++)
            chk("grant_cnt", grant_cnt[i*16 +: 16], 64'(gcnt[i] > 65535 ? 65535 : gcnt[i]));
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
